// File: rtl/usb_uart_tx_arbiter_pkg.sv
// Shared types and helpers for the USB-serial transmit arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package usb_uart_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // ~21.8 ms of owner silence at 48 MHz before the pipe is reclaimed
    localparam int TIMEOUT_W_DEFAULT = 20;

    // Index width for n requesters; never returns less than 1 bit
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_if.sv
// Requester-side byte streams plus the single byte pipe into usb_uart.
// Latency: n/a (wires only).
// Backpressure: valid/ready per stream; byte i lives at req_data[8i+7:8i].
interface usb_uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         uart_in_data;
    logic               uart_in_valid;
    logic               uart_in_ready;

    // master: requesters plus the usb_uart sink
    modport master (
        output req_data, req_valid, req_last, uart_in_ready,
        input  req_ready, uart_in_data, uart_in_valid
    );

    // slave: the arbiter
    modport slave (
        input  req_data, req_valid, req_last, uart_in_ready,
        output req_ready, uart_in_data, uart_in_valid
    );
endinterface

// File: rtl/usb_uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; req in, choice out (any, onehot, idx).
module rr_pick
    import usb_uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the nearest
    // requester after 'last' is the one left standing; no early exit needed.
    always_comb begin
        any      = 1'b0;
        onehot   = '0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = N; off >= 1; off--) begin
            cand = int'(last) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                any              = 1'b1;
                onehot           = '0;
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the usb_uart TX byte pipe.
// Latency: 1 cycle request->grant; bytes pass through combinationally; 1-cycle gap between messages.
// Backpressure: owner sees uart_in_ready directly; non-owners see ready=0; stalled owner reclaimed by timeout.
// Ports: clk_48mhz, reset (sync, active-high); bus (slave: req_* in, req_ready out,
//        uart_in_* out, uart_in_ready in); grant (one-hot owner), busy, timeout_pulse.
module usb_uart_tx_arbiter
    import usb_uart_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic                     clk_48mhz,
    input  logic                     reset,
    usb_uart_tx_arbiter_if.slave     bus,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     timeout_pulse
);

    localparam int IW = clog2(N_REQ);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;
    // Reclaim fires on the idle cycle that would take the counter to all-ones
    localparam logic [TIMEOUT_W-1:0] TMO_PRE = TMO_MAX - TIMEOUT_W'(1);

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_owner_q, last_owner_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic                 tmo_q, tmo_d;

    logic                 pick_any;
    logic [N_REQ-1:0]     pick_onehot;
    logic [IW-1:0]        pick_idx;

    logic                 owner_vld;
    logic                 owner_last;
    logic                 xfer;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (bus.req_valid),
        .last   (last_owner_q),
        .any    (pick_any),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign owner_vld  = bus.req_valid[owner_q];
    assign owner_last = bus.req_last[owner_q];
    // Reset squashes the handshake so the byte on the bus that cycle is not consumed
    assign xfer       = (state_q == ST_OWN) && owner_vld && bus.uart_in_ready && !reset;

    // Owner passthrough; uart_in_valid never depends on uart_in_ready
    always_comb begin
        bus.uart_in_data  = '0;
        bus.uart_in_valid = 1'b0;
        bus.req_ready     = '0;
        if ((state_q == ST_OWN) && !reset) begin
            bus.uart_in_data       = bus.req_data[{owner_q, 3'b000} +: 8];
            bus.uart_in_valid      = owner_vld;
            bus.req_ready[owner_q] = bus.uart_in_ready;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        tcnt_d       = tcnt_q;
        tmo_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    tcnt_d  = '0;
                end
            end
            ST_OWN: begin
                if (xfer) begin
                    tcnt_d = '0;
                    if (owner_last) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                        grant_d      = '0;
                    end
                end else if (!owner_vld) begin
                    // Only owner silence counts; a host stall (ready low) does not
                    if (tcnt_q == TMO_PRE) begin
                        tmo_d        = 1'b1;
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        tcnt_d       = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(N_REQ - 1);
            grant_q      <= '0;
            tcnt_q       <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            tcnt_q       <= tcnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q == ST_OWN);
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Directed bench for usb_uart_tx_arbiter (N_REQ=4, TIMEOUT_W=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// A monitor logs every accepted byte for end-of-scenario stream checks.
module tb_usb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    logic         clk_48mhz = 1'b0;
    logic         reset;
    logic [N-1:0] grant;
    logic         busy;
    logic         timeout_pulse;

    usb_uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    usb_uart_tx_arbiter #(
        .N_REQ     (N),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .bus           (bus),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int vectors     = 0;
    int miscompares = 0;

    // status word: grant[3:0], busy, timeout_pulse, uart_in_valid, req_ready[3:0]
    logic [10:0] st;
    logic [10:0] exp_st;
    logic [71:0] exp_rx;
    assign st = {grant, busy, timeout_pulse, bus.uart_in_valid, bus.req_ready};

    logic [7:0] rx_q[$];

    always @(negedge clk_48mhz) begin
        #2;
        if (bus.uart_in_valid && bus.uart_in_ready) rx_q.push_back(bus.uart_in_data);
    end

    // {count, first eight bytes} of the accepted stream
    function automatic logic [71:0] rx_pack();
        logic [71:0] p;
        p = '0;
        p[71:64] = 8'(rx_q.size());
        for (int i = 0; i < rx_q.size() && i < 8; i++) p[63-8*i -: 8] = rx_q[i];
        return p;
    endfunction

    task automatic set_byte(input int i, input logic [7:0] d, input logic l);
        bus.req_data[i*8 +: 8] = d;
        bus.req_last[i]        = l;
    endtask

    task automatic clear_inputs();
        bus.req_data      = '0;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.uart_in_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_48mhz);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk_48mhz);
        reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk_48mhz);
        reset = 1'b1;
        clear_inputs();
        bus.req_valid = 4'b1111;
        bus.uart_in_ready = 1'b1;
        repeat (2) @(negedge clk_48mhz);
        #1;
        exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rst_status: got %b want %b", st, exp_st); end
        vectors++; if (bus.uart_in_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", bus.uart_in_data); end
        clear_inputs();
        reset = 1'b0;
        @(negedge clk_48mhz); #1;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rst_released_idle: got %b want %b", st, exp_st); end
    endtask

    task automatic test_two_byte();
        do_reset();
        @(negedge clk_48mhz);
        bus.req_valid = 4'b0100; set_byte(2, 8'h41, 1'b0); bus.uart_in_ready = 1'b1;
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_req_cycle: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0100, 3'b101, 4'b0100};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_grant: got %b want %b", st, exp_st); end
        vectors++; if (bus.uart_in_data !== 8'h41) begin miscompares++; $display("FAIL ab_byte_a: got %h want 41", bus.uart_in_data); end
        @(negedge clk_48mhz); set_byte(2, 8'h42, 1'b1); #1;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_hold: got %b want %b", st, exp_st); end
        vectors++; if (bus.uart_in_data !== 8'h42) begin miscompares++; $display("FAIL ab_byte_b: got %h want 42", bus.uart_in_data); end
        // after owner 2, requesters 1 and 3 compete: 3 must win
        @(negedge clk_48mhz);
        bus.req_valid = 4'b1010; set_byte(1, 8'h11, 1'b1); set_byte(3, 8'h33, 1'b1);
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_gap: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b1000, 3'b101, 4'b1000};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_next_owner3: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = 4'b0010; #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_gap2: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL ab_owner1: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = '0;
        #3; exp_rx = {8'd4, 8'h41, 8'h42, 8'h33, 8'h11, 32'h0};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL ab_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    task automatic test_rr_all();
        do_reset();
        bus.uart_in_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_48mhz);
            if (k == 0) begin
                bus.req_valid = 4'b1111;
                for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i), 1'b1);
            end else begin
                bus.req_valid[k-1] = 1'b0;
            end
            #1; exp_st = '0;
            vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rr_gap%0d: got %b want %b", k, st, exp_st); end
            @(negedge clk_48mhz); #1; exp_st = {4'(1 << k), 3'b101, 4'(1 << k)};
            vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", k, st, exp_st); end
            vectors++; if (bus.uart_in_data !== 8'(8'h10 + k)) begin miscompares++; $display("FAIL rr_data%0d: got %h want %h", k, bus.uart_in_data, 8'(8'h10 + k)); end
        end
        @(negedge clk_48mhz); bus.req_valid = '0;
        #3; exp_rx = {8'd4, 8'h10, 8'h11, 8'h12, 8'h13, 32'h0};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL rr_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        @(negedge clk_48mhz);
        bus.req_valid = 4'b1010; set_byte(1, 8'hA0, 1'b0); set_byte(3, 8'hB3, 1'b1); bus.uart_in_ready = 1'b1;
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rt_idle: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hA0) begin miscompares++; $display("FAIL rt_b0: got %b/%h want %b/a0", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(1, 8'hA1, 1'b0); bus.uart_in_ready = 1'b0; #1; exp_st = {4'b0010, 3'b101, 4'b0000};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hA1) begin miscompares++; $display("FAIL rt_stall1: got %b/%h want %b/a1", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); #1;
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hA1) begin miscompares++; $display("FAIL rt_stall2: got %b/%h want %b/a1", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.uart_in_ready = 1'b1; #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hA1) begin miscompares++; $display("FAIL rt_resume: got %b/%h want %b/a1", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(1, 8'hA2, 1'b1); #1;
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hA2) begin miscompares++; $display("FAIL rt_last: got %b/%h want %b/a2", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid[1] = 1'b0; #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rt_gap: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b1000, 3'b101, 4'b1000};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hB3) begin miscompares++; $display("FAIL rt_waiter: got %b/%h want %b/b3", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = '0;
        #3; exp_rx = {8'd4, 8'hA0, 8'hA1, 8'hA2, 8'hB3, 32'h0};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL rt_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk_48mhz);
        bus.req_valid = 4'b1000; set_byte(3, 8'hC0, 1'b0); bus.uart_in_ready = 1'b0;
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL to_idle: got %b want %b", st, exp_st); end
        // host stalled well past the timeout with the owner still valid: no reclaim
        for (int j = 0; j < 20; j++) begin
            @(negedge clk_48mhz);
            if (j == 0) begin bus.req_valid = 4'b1001; set_byte(0, 8'hD0, 1'b1); end
            #1; exp_st = {4'b1000, 3'b101, 4'b0000};
            vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL to_host_stall%0d: got %b want %b", j, st, exp_st); end
        end
        @(negedge clk_48mhz); bus.uart_in_ready = 1'b1; #1; exp_st = {4'b1000, 3'b101, 4'b1000};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hC0) begin miscompares++; $display("FAIL to_byte0: got %b/%h want %b/c0", st, bus.uart_in_data, exp_st); end
        // owner goes silent: 15 cycles still owned, then the reclaim pulse
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk_48mhz);
            if (j == 1) bus.req_valid[3] = 1'b0;
            #1; exp_st = {4'b1000, 3'b100, 4'b1000};
            vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL to_silent%0d: got %b want %b", j, st, exp_st); end
        end
        @(negedge clk_48mhz); #1; exp_st = {4'b0000, 3'b010, 4'b0000};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL to_pulse: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0001, 3'b101, 4'b0001};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'hD0) begin miscompares++; $display("FAIL to_regrant0: got %b/%h want %b/d0", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = '0; #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL to_done: got %b want %b", st, exp_st); end
        #2; exp_rx = {8'd2, 8'hC0, 8'hD0, 48'h0};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL to_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_48mhz);
        bus.req_valid = 4'b0001; set_byte(0, 8'h5F, 1'b1); bus.uart_in_ready = 1'b1;
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rm_idle: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0001, 3'b101, 4'b0001};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h5F) begin miscompares++; $display("FAIL rm_first_msg: got %b/%h want %b/5f", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(0, 8'h50, 1'b0); #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rm_gap: got %b want %b", st, exp_st); end
        for (int b = 0; b < 5; b++) begin
            @(negedge clk_48mhz);
            set_byte(0, 8'(8'h50 + b), 1'b0);
            #1; exp_st = {4'b0001, 3'b101, 4'b0001};
            vectors++; if (st !== exp_st || bus.uart_in_data !== 8'(8'h50 + b)) begin miscompares++; $display("FAIL rm_byte%0d: got %b/%h want %b/%h", b, st, bus.uart_in_data, exp_st, 8'(8'h50 + b)); end
        end
        // byte 5 presented with reset asserted: handshake suppressed
        @(negedge clk_48mhz);
        set_byte(0, 8'h55, 1'b0); reset = 1'b1; bus.req_valid = 4'b0011; set_byte(1, 8'h60, 1'b1);
        #1; exp_st = {4'b0001, 3'b100, 4'b0000};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rm_reset_cycle: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); reset = 1'b0; #1; exp_st = '0;
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h00) begin miscompares++; $display("FAIL rm_after_reset: got %b/%h want %b/00", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(0, 8'h50, 1'b1); #1; exp_st = {4'b0001, 3'b101, 4'b0001};
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rm_rewin0: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); bus.req_valid[0] = 1'b0; #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL rm_gap2: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h60) begin miscompares++; $display("FAIL rm_owner1: got %b/%h want %b/60", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = '0;
        #3; exp_rx = {8'd8, 8'h5F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h50, 8'h60};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL rm_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk_48mhz);
        bus.req_valid = 4'b0010; set_byte(1, 8'h70, 1'b0); bus.uart_in_ready = 1'b1;
        #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL bb_idle: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = 4'b0110; set_byte(2, 8'h80, 1'b1);
        #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h70) begin miscompares++; $display("FAIL bb_own1: got %b/%h want %b/70", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(1, 8'h71, 1'b1); #1;
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h71) begin miscompares++; $display("FAIL bb_last1: got %b/%h want %b/71", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); set_byte(1, 8'h72, 1'b0); #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL bb_gap: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0100, 3'b101, 4'b0100};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h80) begin miscompares++; $display("FAIL bb_fair2: got %b/%h want %b/80", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid[2] = 1'b0; #1; exp_st = '0;
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL bb_gap2: got %b want %b", st, exp_st); end
        @(negedge clk_48mhz); #1; exp_st = {4'b0010, 3'b101, 4'b0010};
        vectors++; if (st !== exp_st || bus.uart_in_data !== 8'h72) begin miscompares++; $display("FAIL bb_back1: got %b/%h want %b/72", st, bus.uart_in_data, exp_st); end
        @(negedge clk_48mhz); bus.req_valid = '0;
        #3; exp_rx = {8'd4, 8'h70, 8'h71, 8'h80, 8'h72, 32'h0};
        vectors++; if (rx_pack() !== exp_rx) begin miscompares++; $display("FAIL bb_stream: got %h want %h", rx_pack(), exp_rx); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_two_byte();
        test_rr_all();
        test_ready_toggle();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
